// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 one-bit mux.
// Bounded grant hold time, registered select and data output.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_d;
    logic [3:0]       gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       others;
    logic [1:0]       nxt;

    // First set bit of r scanning start, start+1, ... (mod 4).
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] start
    );
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        onehot = 4'b0001 << i;
    endfunction

    assign others = req & ~gnt;
    assign nxt    = sel + 2'd1;
    assign busy   = |gnt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        sel_d   = sel;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = rr_pick(req, ptr_q);
                    gnt_d   = onehot(sel_d);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    ptr_d = nxt;
                    cnt_d = '0;
                    if (|req) begin
                        sel_d = rr_pick(req, nxt);
                        gnt_d = onehot(sel_d);
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Hold limit reached: rotate if contended, else renew.
                    cnt_d = '0;
                    if (|others) begin
                        sel_d = rr_pick(others, nxt);
                        gnt_d = onehot(sel_d);
                        ptr_d = nxt;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            sel     <= '0;
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            // Uses the current owner, so y trails the grant by a cycle.
            y       <= (|gnt) ? din[sel] : 1'b0;
            y_valid <= |gnt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: owner/hold-time model checked every
// cycle on two instances (MAX_HOLD=4 and MAX_HOLD=1), plus literals.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;

    logic [1:0] sel_a, sel_b;
    logic [3:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, y_a, y_b, yv_a, yv_b;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .sel(sel_a), .gnt(gnt_a), .busy(busy_a),
        .y(y_a), .y_valid(yv_a)
    );

    mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .sel(sel_b), .gnt(gnt_b), .busy(busy_b),
        .y(y_b), .y_valid(yv_b)
    );

    // owner = -1 when idle; held = cycles the owner has held so far
    typedef struct packed {
        int owner;
        int ptr;
        int held;
        int last;
        bit y;
        bit yv;
    } mstate_t;

    mstate_t ma, mb;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic [3:0] r,
                                      input logic [3:0] d, input bit rn,
                                      input int mh);
        mstate_t n = s;
        logic [3:0] oth;
        if (!rn) begin
            n = '0;
            n.owner = -1;
            return n;
        end
        n.yv = (s.owner >= 0);
        n.y  = (s.owner >= 0) ? d[s.last] : 1'b0;
        if (s.owner < 0) begin
            if (r != 0) begin
                n.owner = first_from(r, s.ptr);
                n.held = 1;
            end
        end else if (!r[s.owner]) begin
            n.ptr = (s.owner + 1) % 4;
            n.owner = (r != 0) ? first_from(r, n.ptr) : -1;
            n.held = 1;
        end else if (s.held < mh) begin
            n.held = s.held + 1;
        end else begin
            oth = r;
            oth[s.owner] = 1'b0;
            n.held = 1;
            if (oth != 0) begin
                n.ptr = (s.owner + 1) % 4;
                n.owner = first_from(oth, n.ptr);
            end
        end
        if (n.owner >= 0) n.last = n.owner;
        return n;
    endfunction

    function automatic logic [3:0] mgnt(input mstate_t s);
        return (s.owner < 0) ? 4'b0000 : 4'(1 << s.owner);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, required %b", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ma <= mstep(ma, req, din, rst_n, 4);
        mb <= mstep(mb, req, din, rst_n, 1);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.gnt",  gnt_a,          mgnt(ma));
            chk("a.sel",  4'(sel_a),      4'(ma.last));
            chk("a.busy", 4'(busy_a),     4'(ma.owner >= 0));
            chk("a.y",    4'(y_a),        4'(ma.y));
            chk("a.yv",   4'(yv_a),       4'(ma.yv));
            chk("b.gnt",  gnt_b,          mgnt(mb));
            chk("b.sel",  4'(sel_b),      4'(mb.last));
            chk("b.busy", 4'(busy_b),     4'(mb.owner >= 0));
            chk("b.y",    4'(y_b),        4'(mb.y));
            chk("b.yv",   4'(yv_b),       4'(mb.yv));
        end
    end

    task automatic apply(input logic [3:0] r, input logic [3:0] d, input int n);
        req = r;
        din = d;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(4'b0000, 4'b0000, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_on = 1;
        chk("L.rst.gnt", gnt_a, 4'b0000);
        chk("L.rst.yv",  4'(yv_a), 4'b0000);
        chk("L.rst.sel", 4'(sel_a), 4'b0000);

        // single requester c
        apply(4'b0100, 4'b0100, 1);
        chk("L.c.gnt",  gnt_a, 4'b0100);
        chk("L.c.sel",  4'(sel_a), 4'd2);
        chk("L.c.busy", 4'(busy_a), 4'd1);
        apply(4'b0100, 4'b0100, 1);
        chk("L.c.y",  4'(y_a), 4'd1);
        chk("L.c.yv", 4'(yv_a), 4'd1);
        apply(4'b0000, 4'b0000, 1);
        chk("L.c.drop", gnt_a, 4'b0000);
        chk("L.c.yv1", 4'(yv_a), 4'd1);
        apply(4'b0000, 4'b0000, 1);
        chk("L.c.yv0", 4'(yv_a), 4'd0);

        // full contention, 4-cycle rotation
        do_reset();
        apply(4'b1111, 4'b1010, 1);
        chk("L.rr.g0", gnt_a, 4'b0001);
        apply(4'b1111, 4'b1010, 3);
        chk("L.rr.g0h", gnt_a, 4'b0001);
        apply(4'b1111, 4'b0110, 1);
        chk("L.rr.g1", gnt_a, 4'b0010);
        apply(4'b1111, 4'b0110, 4);
        chk("L.rr.g2", gnt_a, 4'b0100);
        chk("L.rr.sel2", 4'(sel_a), 4'd2);
        apply(4'b1111, 4'b1001, 8);
        chk("L.rr.g0w", gnt_a, 4'b0001);

        // release handoffs
        do_reset();
        apply(4'b0001, 4'b0001, 1);
        apply(4'b1010, 4'b0010, 1);
        chk("L.rel.1", gnt_a, 4'b0010);
        chk("L.rel.y", 4'(y_a), 4'd0);
        apply(4'b1000, 4'b1000, 1);
        chk("L.rel.3", gnt_a, 4'b1000);
        apply(4'b0001, 4'b0001, 1);
        chk("L.rel.wrap", gnt_a, 4'b0001);

        // sole requester renewal
        for (int i = 0; i < 20; i++) begin
            apply(4'b0001, 4'(i), 1);
            chk("L.sole.a", gnt_a, 4'b0001);
            chk("L.sole.b", gnt_b, 4'b0001);
        end

        // reset mid-grant
        do_reset();
        apply(4'b0100, 4'b0100, 3);
        rst_n = 1'b0;
        apply(4'b0100, 4'b0100, 1);
        chk("L.mr.gnt", gnt_a, 4'b0000);
        chk("L.mr.y",   4'(y_a), 4'd0);
        chk("L.mr.yv",  4'(yv_a), 4'd0);
        rst_n = 1'b1;
        apply(4'b1111, 4'b0000, 1);
        chk("L.mr.first", gnt_a, 4'b0001);

        // MAX_HOLD=1 alternation
        do_reset();
        apply(4'b0011, 4'b0001, 1);
        chk("L.h1.g0", gnt_b, 4'b0001);
        apply(4'b0011, 4'b0001, 1);
        chk("L.h1.g1", gnt_b, 4'b0010);
        chk("L.h1.y1", 4'(y_b), 4'd1);
        apply(4'b0011, 4'b0001, 1);
        chk("L.h1.g0b", gnt_b, 4'b0001);
        chk("L.h1.y0", 4'(y_b), 4'd0);
        apply(4'b0011, 4'b0010, 6);

        // mixed traffic, model-checked every cycle
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(1, 3));
        end
        rst_n = 1'b1;
        apply(4'b0000, 4'b0000, 2);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
